// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared constants and CPU FSM encoding for the VRAM arbiter
//
// Purpose: fetch-slot positions, active-area geometry and the CPU access
// state encoding used by vram_fetch_sched and vram_arbiter.
// Ports: none (package).

package vram_pkg;

  // Position within an 8-pixel tile where the two display reads happen.
  localparam logic [2:0] NAME_SLOT = 3'd6;
  localparam logic [2:0] PAT_SLOT  = 3'd7;

  // Visible geometry: 192 fetched lines, 32 tiles per line.
  localparam logic [8:0] ACTIVE_LINES = 9'd192;
  localparam int         TILE_COLS    = 32;
  localparam int         TILE_W       = $clog2(TILE_COLS);

  // Fetch runs two pixels ahead so the pattern byte lands on the tile's
  // first pixel.
  localparam logic [8:0] FETCH_LEAD = 9'd2;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } cpu_state_e;

endpackage

// File: rtl/vram_fetch_sched.sv
// rtl/vram_fetch_sched.sv - display fetch slot decode and pattern byte register
//
// Purpose: decodes xPos/yPos into NAME/PAT display slots, forms the display
// VRAM address for those slots and captures the fetched pattern byte.
// Ports:
//   clk, reset        pixel clock, async active-high reset
//   x_pos, y_pos      signed 9-bit raster position from the sync generator
//   ram_rdata         registered VRAM read data
//   name_slot         this cycle reads the name table
//   pat_slot          this cycle reads the pattern table
//   disp_addr         VRAM address for the current display slot (0 otherwise)
//   pat_byte          pattern byte for the current tile
//   pat_valid         one-cycle strobe when pat_byte updates

module vram_fetch_sched
  import vram_pkg::*;
#(
  parameter int                ADDR_W    = 14,
  parameter logic [ADDR_W-1:0] NAME_BASE = 14'h1800,
  parameter logic [ADDR_W-1:0] PAT_BASE  = 14'h0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [8:0]        x_pos,
  input  logic [8:0]        y_pos,
  input  logic [7:0]        ram_rdata,
  output logic              name_slot,
  output logic              pat_slot,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [7:0]        pat_byte,
  output logic              pat_valid
);

  // Upper bits of fx = xPos + FETCH_LEAD (9-bit wrap); the MSB is the
  // sign of fx and the rest is the target tile.
  logic [TILE_W:0]   fx_tile;
  logic [TILE_W-1:0] tile;
  logic              fetch_line;
  logic              fetch_col;

  logic       pat_pend_q, pat_pend_d;
  logic [7:0] pat_byte_q, pat_byte_d;

  always_comb begin
    fx_tile    = (TILE_W + 1)'((x_pos + FETCH_LEAD) >> 3);
    tile       = fx_tile[TILE_W-1:0];
    fetch_line = !y_pos[8] && (y_pos < ACTIVE_LINES);
    fetch_col  = !fx_tile[TILE_W];

    name_slot = fetch_line && fetch_col && (x_pos[2:0] == NAME_SLOT);
    pat_slot  = fetch_line && fetch_col && (x_pos[2:0] == PAT_SLOT);

    // In the PAT slot ram_rdata carries the name byte read one cycle earlier.
    disp_addr = '0;
    if (name_slot) begin
      disp_addr = NAME_BASE + ADDR_W'({y_pos[7:3], tile});
    end else if (pat_slot) begin
      disp_addr = PAT_BASE + ADDR_W'({ram_rdata, y_pos[2:0]});
    end
  end

  always_comb begin
    pat_pend_d = pat_slot;
    pat_byte_d = pat_byte_q;
    if (pat_pend_q) begin
      pat_byte_d = ram_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_pend_q <= 1'b0;
      pat_byte_q <= 8'h00;
    end else begin
      pat_pend_q <= pat_pend_d;
      pat_byte_q <= pat_byte_d;
    end
  end

  // The pattern data only arrives on the strobe cycle, so the strobe cycle
  // forwards ram_rdata directly; the register holds it afterwards.
  assign pat_valid = pat_pend_q;
  assign pat_byte  = pat_pend_q ? ram_rdata : pat_byte_q;

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter between display fetch and CPU
//
// Purpose: gives the display its NAME/PAT fetch slots unconditionally and
// hands every remaining cycle to a two-state CPU access FSM.
// Ports:
//   clk, reset                 pixel clock, async active-high reset
//   xPos, yPos                 signed raster position
//   cpuReq/cpuWe/cpuAddr/cpuWdata  CPU request, held until cpuAck
//   cpuAck                     one-cycle completion pulse
//   cpuRdata                   read data, valid with cpuAck, held afterwards
//   ramAddr/ramWe/ramWdata     VRAM command
//   ramRdata                   VRAM read data, one cycle after the address
//   patByte/patValid           pattern byte and its update strobe

module vram_arbiter
  import vram_pkg::*;
#(
  parameter int                ADDR_W    = 14,
  parameter logic [ADDR_W-1:0] NAME_BASE = 14'h1800,
  parameter logic [ADDR_W-1:0] PAT_BASE  = 14'h0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [8:0]        xPos,
  input  logic [8:0]        yPos,
  input  logic              cpuReq,
  input  logic              cpuWe,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic [7:0]        cpuWdata,
  output logic              cpuAck,
  output logic [7:0]        cpuRdata,
  output logic [ADDR_W-1:0] ramAddr,
  output logic              ramWe,
  output logic [7:0]        ramWdata,
  input  logic [7:0]        ramRdata,
  output logic [7:0]        patByte,
  output logic              patValid
);

  logic              name_slot;
  logic              pat_slot;
  logic [ADDR_W-1:0] disp_addr;
  logic              cpu_slot;
  logic              grant;

  cpu_state_e state_q, state_d;
  logic       cpu_we_q, cpu_we_d;
  logic [7:0] rdata_q, rdata_d;

  vram_fetch_sched #(
    .ADDR_W    (ADDR_W),
    .NAME_BASE (NAME_BASE),
    .PAT_BASE  (PAT_BASE)
  ) u_fetch_sched (
    .clk       (clk),
    .reset     (reset),
    .x_pos     (xPos),
    .y_pos     (yPos),
    .ram_rdata (ramRdata),
    .name_slot (name_slot),
    .pat_slot  (pat_slot),
    .disp_addr (disp_addr),
    .pat_byte  (patByte),
    .pat_valid (patValid)
  );

  // Grants only come from IDLE, so a request still held during ACK is
  // never issued twice.
  always_comb begin
    cpu_slot = !name_slot && !pat_slot;
    grant    = !reset && (state_q == IDLE) && cpu_slot && cpuReq;
  end

  always_comb begin
    state_d  = state_q;
    cpu_we_d = cpu_we_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d  = ACK;
          cpu_we_d = cpuWe;
        end
      end
      ACK: begin
        state_d = IDLE;
        if (!cpu_we_q) begin
          rdata_d = ramRdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cpu_we_q <= 1'b0;
      rdata_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      cpu_we_q <= cpu_we_d;
      rdata_q  <= rdata_d;
    end
  end

  // Read data is forwarded on the ack cycle; writes leave the old value.
  assign cpuAck   = (state_q == ACK);
  assign cpuRdata = (cpuAck && !cpu_we_q) ? ramRdata : rdata_q;

  // VRAM command mux; reset forces an idle command without waiting for a clock.
  always_comb begin
    ramAddr  = '0;
    ramWe    = 1'b0;
    ramWdata = 8'h00;
    if (!reset) begin
      if (name_slot || pat_slot) begin
        ramAddr = disp_addr;
      end else if (grant) begin
        ramAddr  = cpuAddr;
        ramWe    = cpuWe;
        ramWdata = cpuWdata;
      end
    end
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
Shares one single-port, synchronous-read video RAM between the display tile fetch and CPU accesses. Display fetch slots come from the sync generator's xPos/yPos. The display always wins its slots, and the CPU gets every other cycle. The block sits between the sync generator, the CPU bus bridge and the VRAM, and hands one pattern byte per 8-pixel tile to the pixel shifter.

Parameters:
ADDR_W, 14, VRAM address width (16 KB).
NAME_BASE, 14'h1800, base address of the 32x24 name table.
PAT_BASE, 14'h0000, base address of the pattern table (8 bytes per tile).

Ports:
clk  in  1  system clock (pixel clock).
reset  in  1  asynchronous, active-high reset.
xPos  in  9  signed pixel column from the sync generator.
yPos  in  9  signed pixel line from the sync generator.
cpuReq  in  1  CPU request; held with cpuWe/cpuAddr/cpuWdata until cpuAck.
cpuWe  in  1  1 = write, 0 = read.
cpuAddr  in  ADDR_W  CPU address.
cpuWdata  in  8  CPU write data.
cpuAck  out  1  one-cycle completion pulse.
cpuRdata  out  8  read data; valid while cpuAck = 1, held afterwards.
ramAddr  out  ADDR_W  VRAM address.
ramWe  out  1  VRAM write enable.
ramWdata  out  8  VRAM write data.
ramRdata  in  8  VRAM read data; registered, valid the cycle after the address.
patByte  out  8  pattern byte for the current tile.
patValid  out  1  one-cycle strobe when patByte updates.

Behaviour:
- fetchLine: yPos[8] == 0 and yPos < 192.
- fx = xPos + 2, computed in 9 bits with wrap.
- fetchCol: fx[8] == 0. Target tile t = fx[7:3], range 0..31.
- Slot NAME: fetchLine, fetchCol and xPos[2:0] == 6.
  - ramAddr = NAME_BASE + {yPos[7:3], t}, with ramWe = 0.
- Slot PAT: fetchLine, fetchCol and xPos[2:0] == 7.
  - ramAddr = PAT_BASE + {ramRdata, yPos[2:0]}, with ramWe = 0.
  - ramRdata here is the name byte from the NAME slot.
- Cycle after a PAT slot:
  - patByte <= ramRdata and patValid = 1.
  - This lands on xPos[2:0] == 0 of tile t, i.e. xPos = 8t.
  - Tile 0 is fetched at xPos = -2 and -1.
- Every other cycle is a CPU slot.
- CPU FSM has two states:
  - IDLE: on a CPU slot with cpuReq = 1, drive ramAddr = cpuAddr, ramWe = cpuWe, ramWdata = cpuWdata, and go to ACK.
  - ACK: cpuAck = 1 and cpuRdata <= ramRdata (for reads; after writes cpuRdata holds its old value). No grant is issued in ACK, so a still-high cpuReq is never double-issued. Return to IDLE.
  - Peak CPU throughput is one access per 2 cycles.
- Display slots preempt the CPU. A request arriving in a NAME or PAT slot waits; cpuReq must stay high.
- An ACK that coincides with a display slot is legal: the CPU data comes from the previous cycle's address.
- Idle cycles (no slot, no request): ramAddr = 0, ramWe = 0, ramWdata = 0.
- Worst-case CPU latency in the active area is 2 cycles wait + 1 cycle ack.
- During blanking (fetchLine = 0 or fetchCol = 0) the CPU is never stalled.
- Reset, asynchronous:
  - FSM to IDLE.
  - cpuAck = 0, cpuRdata = 0, patByte = 0, patValid = 0, ramWe = 0, ramAddr = 0, ramWdata = 0.
  - A grant in flight when reset hits gets no ack; the CPU must reissue.
- Width rules: name and pattern address sums are ADDR_W bits and wrap modulo 2^ADDR_W.
- ramWe is never asserted in display slots.

Decomposition:
- Shared package vram_pkg: NAME_SLOT = 3'd6, PAT_SLOT = 3'd7, ACTIVE_LINES = 192, TILE_COLS = 32, FETCH_LEAD = 2, and the FSM state encoding (IDLE, ACK).
- One natural sub-module: vram_fetch_sched. It is combinational plus the patByte register, decodes xPos/yPos into slot type and display address, and emits patByte/patValid.
- The top level holds the CPU FSM and the address/we mux.

Test Plan:
1. Blank-period write: yPos = 250, cpuReq write addr 14'h0123 data 8'hA5 -> ramWe = 1 with ramAddr 0x0123 that cycle; cpuAck the next cycle; read back gives cpuRdata = 8'hA5.
2. Tile fetch: name[0x1800 + 32*1 + 0] = 8'h05, pattern[0x0028 + 3] = 8'h3C; at yPos = 11 sweep xPos = -2..0 -> ramAddr 0x1820, then 0x002B; patValid = 1 with patByte = 0x3C at xPos = 0.
3. Collision: cpuReq read asserted at xPos = 5 on an active line -> grant at xPos = 5, ack at xPos = 6 while NAME is issued; a request arriving at xPos = 6 is granted at xPos = 8 (since 0 mod 8) and acked at 9.
4. Back-to-back: cpuReq held high continuously in blanking -> grants on alternating cycles, exactly one ack per grant, no duplicate write.
5. Boundaries: yPos = 192 or xPos = 254 -> no display slots (fx = 256 excluded); xPos = 246,247 -> tile 31 fetched; yPos = -1 -> no fetch.
6. Reset mid-access: assert reset in the grant cycle -> cpuAck stays 0; all outputs 0 immediately (async); after release, the same request completes normally.
